// File: rtl/data_memory_ctrl.sv
// Byte-addressable word RAM with RV32 sized/signed loads and stores, busywait
// handshake with configurable latency, fault detection, post-reset clear and a debug snapshot port.
module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1,
  parameter int DBG_IDX_W   = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           read,
  input  logic [2:0]           write,
  input  logic [31:0]          address,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 busywait,
  output logic                 fault,
  input  logic                 dbg_req,
  input  logic [DBG_IDX_W-1:0] dbg_index,
  output logic                 dbg_valid,
  output logic [39:0]          dbg_data
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit ZERO_LAT = (LATENCY == 0);

  // Handshake: a request (read[3] or write[2]) in IDLE raises busywait in the
  // same cycle; busywait falls in the single DONE cycle, when results are valid.
  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_ptr;
  logic [2:0]       wait_cnt;
  logic [3:0]       rd_q;
  logic [2:0]       wr_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             req;
  logic             finish;
  logic [3:0]       rd_e;
  logic [2:0]       wr_e;
  logic [31:0]      a_e;
  logic [31:0]      wd_e;
  logic             is_load;
  logic             is_store;
  logic [1:0]       size;
  logic             acc_fault;
  logic [IDX_W-1:0] widx;
  logic [31:0]      word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      load_val;
  logic [3:0]       be;
  logic [31:0]      sdata;
  logic [31:0]      dbg_ext;

  assign req = read[3] | write[2];
  // The access completes at the edge that enters DONE; with zero latency that
  // edge is the one accepting the request, so the live inputs are used.
  assign finish = (state == IDLE && req && ZERO_LAT) || (state == WAIT && wait_cnt == 3'd1);

  assign rd_e = (state == IDLE) ? read      : rd_q;
  assign wr_e = (state == IDLE) ? write     : wr_q;
  assign a_e  = (state == IDLE) ? address   : addr_q;
  assign wd_e = (state == IDLE) ? writedata : wdata_q;

  assign is_load  = rd_e[3];
  assign is_store = wr_e[2] & ~rd_e[3];
  assign size     = is_load ? rd_e[1:0] : wr_e[1:0];
  assign widx     = a_e[IDX_W+1:2];
  assign word     = mem[widx];

  always_comb begin
    acc_fault = 1'b0;
    if (rd_e[3] && wr_e[2]) acc_fault = 1'b1;
    if (is_load && (rd_e[1:0] == 2'b11 || (rd_e[2] && rd_e[1]))) acc_fault = 1'b1;
    if (is_store && wr_e[1:0] == 2'b11) acc_fault = 1'b1;
    if (size == 2'b01 && a_e[0]) acc_fault = 1'b1;
    if (size == 2'b10 && a_e[1:0] != 2'b00) acc_fault = 1'b1;
    if ({2'b00, a_e[31:2]} >= 32'(DEPTH_WORDS)) acc_fault = 1'b1;
  end

  always_comb begin
    byte_v = word[7:0];
    case (a_e[1:0])
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = a_e[1] ? word[31:16] : word[15:0];
    case (rd_e[2:0])
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, byte_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    sdata = wd_e;
    case (wr_e[1:0])
      2'b00: begin
        be    = 4'b0001 << a_e[1:0];
        sdata = {4{wd_e[7:0]}};
      end
      2'b01: begin
        be    = a_e[1] ? 4'b1100 : 4'b0011;
        sdata = {2{wd_e[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    busywait = 1'b1;
    case (state)
      CLEAR:   busywait = 1'b1;
      IDLE:    busywait = req;
      WAIT:    busywait = 1'b1;
      DONE:    busywait = 1'b0;
      default: busywait = 1'b1;
    endcase
  end

  // State is reset asynchronously, so a store in flight can never reach its
  // commit edge once reset has been asserted.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= 32'd0;
    end else if (finish && is_store && !acc_fault) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= sdata[8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      wait_cnt <= 3'd0;
      rd_q     <= 4'd0;
      wr_q     <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      readdata <= 32'd0;
      fault    <= 1'b0;
    end else begin
      fault <= 1'b0;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == IDX_W'(DEPTH_WORDS - 1)) state <= IDLE;
        end
        IDLE: begin
          if (req) begin
            rd_q     <= read;
            wr_q     <= write;
            addr_q   <= address;
            wdata_q  <= writedata;
            wait_cnt <= 3'(LATENCY);
            state    <= ZERO_LAT ? DONE : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (finish) begin
        fault <= acc_fault;
        if (is_load) readdata <= acc_fault ? 32'd0 : load_val;
      end
    end
  end

  assign dbg_ext = 32'(dbg_index);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dbg_valid <= 1'b0;
      dbg_data  <= 40'd0;
    end else begin
      dbg_valid <= dbg_req;
      if (dbg_req)
        dbg_data <= {(dbg_ext < 32'(DEPTH_WORDS)) ? mem[dbg_ext[IDX_W-1:0]] : 32'd0,
                     dbg_ext[7:0]};
    end
  end

endmodule
